// File: rtl/bp_pkg.sv
// Shared types and width helpers for the BTB: predictor counter encoding,
// per-entry state record and index/tag width derivation.
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_e;

  // Tag and target widths depend on module parameters, so they live in
  // parallel arrays beside this record inside the table.
  typedef struct packed {
    logic    valid;
    bp_ctr_e ctr;
  } bp_entry_t;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(input int entries, input int addr_w);
    return addr_w - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup, EX resolution and statistics signals between the core and the BTB.
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 32,
  parameter int CTR_W  = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              if_valid;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              ex_valid;
  logic [ADDR_W-1:0] ex_pc;
  logic              ex_is_branch;
  logic              ex_taken;
  logic [ADDR_W-1:0] ex_target;
  logic              ex_pred_taken;
  logic [ADDR_W-1:0] ex_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CTR_W-1:0]  lookup_count;
  logic [CTR_W-1:0]  mispred_count;

  modport master (
    output if_pc, if_valid, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc, lookup_count, mispred_count
  );

  modport slave (
    input  if_pc, if_valid, ex_valid, ex_pc, ex_is_branch, ex_taken, ex_target,
           ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc, lookup_count, mispred_count
  );
endinterface

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating predictor counter next-state: count up on taken, down otherwise.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic    taken,
  input  bp_ctr_e ctr,
  output bp_ctr_e ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = bp_ctr_e'(ctr + 2'd1);
    end else begin
      if (ctr != SNT) ctr_next = bp_ctr_e'(ctr - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped flop-based BTB with 2-bit predictors: same-cycle fetch lookup,
// EX-stage training, mispredict/redirect generation and saturating statistics.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int MODE    = 1,
  parameter int CTR_W   = 32
) (
  input  logic clk,
  input  logic reset,
  branch_predictor_btb_if.slave bus
);

  localparam int IDX_W = idx_w(ENTRIES);
  localparam int TAG_W = tag_w(ENTRIES, ADDR_W);

  bp_entry_t         st_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q [ENTRIES];
  logic [ADDR_W-1:0] tgt_q [ENTRIES];
  logic [CTR_W-1:0]  lookup_q;
  logic [CTR_W-1:0]  mispred_q;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             mispredict_raw;
  bp_ctr_e          ctr_next;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign if_tag = bus.if_pc[ADDR_W-1:IDX_W+2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign ex_tag = bus.ex_pc[ADDR_W-1:IDX_W+2];

  assign if_hit = st_q[if_idx].valid && (tag_q[if_idx] == if_tag);
  assign ex_hit = st_q[ex_idx].valid && (tag_q[ex_idx] == ex_tag);

  bp_sat_ctr2 u_sat_ctr (
    .taken    (bus.ex_taken),
    .ctr      (st_q[ex_idx].ctr),
    .ctr_next (ctr_next)
  );

  always_comb begin
    mispredict_raw = 1'b0;
    if (bus.ex_valid) begin
      if (bus.ex_is_branch)
        mispredict_raw = (bus.ex_pred_taken != bus.ex_taken) ||
                         (bus.ex_taken && (bus.ex_pred_target != bus.ex_target));
      else
        mispredict_raw = bus.ex_pred_taken;
    end
  end

  // Lookup reads pre-update table contents; there is no EX-to-IF bypass.
  assign bus.pred_taken  = reset && (MODE != 0) && if_hit && st_q[if_idx].ctr[1];
  assign bus.pred_target = if_hit ? tgt_q[if_idx] : bus.if_pc + ADDR_W'(4);
  assign bus.mispredict  = reset && mispredict_raw;
  assign bus.redirect_pc = !reset ? '0 :
                           (bus.ex_is_branch && bus.ex_taken) ? bus.ex_target :
                           bus.ex_pc + ADDR_W'(4);
  assign bus.lookup_count  = lookup_q;
  assign bus.mispred_count = mispred_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) st_q[i] <= '{valid: 1'b0, ctr: WNT};
      lookup_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (bus.ex_valid && bus.ex_is_branch) begin
        if (ex_hit) begin
          st_q[ex_idx].ctr <= ctr_next;
          if (bus.ex_taken) tgt_q[ex_idx] <= bus.ex_target;
        end else if (bus.ex_taken) begin
          st_q[ex_idx]  <= '{valid: 1'b1, ctr: WT};
          tag_q[ex_idx] <= ex_tag;
          tgt_q[ex_idx] <= bus.ex_target;
        end
      end else if (bus.ex_valid && bus.ex_pred_taken) begin
        // A non-branch predicted taken aliased onto this slot; drop it.
        st_q[ex_idx].valid <= 1'b0;
      end
      if (bus.if_valid && (lookup_q != '1)) lookup_q <= lookup_q + CTR_W'(1);
      if (mispredict_raw && (mispred_q != '1)) mispred_q <= mispred_q + CTR_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Scoreboard bench for branch_predictor_btb: a dynamic instance with 4-bit
// statistics and a static not-taken instance driven with identical stimulus.
module tb_branch_predictor_btb;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_is_branch;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;

  branch_predictor_btb_if #(.ADDR_W(32), .CTR_W(4))  bus_a ();
  branch_predictor_btb_if #(.ADDR_W(32), .CTR_W(32)) bus_b ();

  assign bus_a.if_pc = if_pc;             assign bus_b.if_pc = if_pc;
  assign bus_a.if_valid = if_valid;       assign bus_b.if_valid = if_valid;
  assign bus_a.ex_valid = ex_valid;       assign bus_b.ex_valid = ex_valid;
  assign bus_a.ex_pc = ex_pc;             assign bus_b.ex_pc = ex_pc;
  assign bus_a.ex_is_branch = ex_is_branch; assign bus_b.ex_is_branch = ex_is_branch;
  assign bus_a.ex_taken = ex_taken;       assign bus_b.ex_taken = ex_taken;
  assign bus_a.ex_target = ex_target;     assign bus_b.ex_target = ex_target;
  assign bus_a.ex_pred_taken = ex_pred_taken;   assign bus_b.ex_pred_taken = ex_pred_taken;
  assign bus_a.ex_pred_target = ex_pred_target; assign bus_b.ex_pred_target = ex_pred_target;

  branch_predictor_btb #(.ENTRIES(16), .ADDR_W(32), .MODE(1), .CTR_W(4)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  branch_predictor_btb #(.ENTRIES(16), .ADDR_W(32), .MODE(0), .CTR_W(32)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ifv;
    logic        pt;
    logic [31:0] tgt;
    logic        mp;
    logic [31:0] rpc;
  } exp_t;

  exp_t  sb_q   [$];
  string name_q [$];

  int n_checks = 0;
  int n_errors = 0;

  bit          cnt_known = 1'b0;
  logic [3:0]  exp_lk_a, exp_mp_a;
  logic [31:0] exp_lk_b, exp_mp_b;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Outputs settle half a cycle after the inputs are driven.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = sb_q.pop_front();
      nm = name_q.pop_front();
      check_val($sformatf("%s.pt", nm), 32'(bus_a.pred_taken), 32'(e.pt));
      if (e.rst) check_val($sformatf("%s.tgt", nm), bus_a.pred_target, e.tgt);
      check_val($sformatf("%s.mp", nm), 32'(bus_a.mispredict), 32'(e.mp));
      check_val($sformatf("%s.rpc", nm), bus_a.redirect_pc, e.rpc);
      check_val($sformatf("%s.pt_static", nm), 32'(bus_b.pred_taken), 32'd0);
      check_val($sformatf("%s.mp_static", nm), 32'(bus_b.mispredict), 32'(e.mp));
      if (cnt_known) begin
        check_val($sformatf("%s.lk_a", nm), 32'(bus_a.lookup_count), 32'(exp_lk_a));
        check_val($sformatf("%s.mpc_a", nm), 32'(bus_a.mispred_count), 32'(exp_mp_a));
        check_val($sformatf("%s.lk_b", nm), bus_b.lookup_count, exp_lk_b);
        check_val($sformatf("%s.mpc_b", nm), bus_b.mispred_count, exp_mp_b);
      end
      if (!e.rst) begin
        exp_lk_a = '0; exp_mp_a = '0; exp_lk_b = '0; exp_mp_b = '0;
        cnt_known = 1'b1;
      end else begin
        if (e.ifv) begin
          if (exp_lk_a != 4'hf) exp_lk_a = exp_lk_a + 4'd1;
          exp_lk_b = exp_lk_b + 32'd1;
        end
        if (e.mp) begin
          if (exp_mp_a != 4'hf) exp_mp_a = exp_mp_a + 4'd1;
          exp_mp_b = exp_mp_b + 32'd1;
        end
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic [31:0] pc, input logic ifv,
                      input logic exv, input logic [31:0] expc, input logic br, input logic tk,
                      input logic [31:0] extgt, input logic ept, input logic [31:0] eptgt,
                      input logic x_pt, input logic [31:0] x_tgt, input logic x_mp,
                      input logic [31:0] x_rpc);
    @(posedge clk);
    #1;
    reset = rst; if_pc = pc; if_valid = ifv;
    ex_valid = exv; ex_pc = expc; ex_is_branch = br; ex_taken = tk; ex_target = extgt;
    ex_pred_taken = ept; ex_pred_target = eptgt;
    sb_q.push_back('{rst: rst, ifv: ifv, pt: x_pt, tgt: x_tgt, mp: x_mp, rpc: x_rpc});
    name_q.push_back(name);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic x_pt,
                      input logic [31:0] x_tgt);
    step(name, 1'b1, pc, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
         x_pt, x_tgt, 1'b0, 32'h4);
  endtask

  initial begin
    reset = 1'b0; if_pc = '0; if_valid = 1'b0; ex_valid = 1'b0; ex_pc = '0;
    ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;

    // Reset holds outputs low and discards the EX update presented with it.
    step("rst0", 0, 32'h40, 1, 1, 32'h40, 1, 1, 32'h20, 0, 32'h44, 0, 32'h0, 0, 32'h0);
    step("rst1", 0, 32'h40, 0, 1, 32'h80, 0, 0, 32'h0,  1, 32'h0,  0, 32'h0, 0, 32'h0);
    look("lk_miss", 32'h40, 0, 32'h44);
    // Allocation with same-cycle lookup of the same index sees the old entry.
    step("ex_beq", 1, 32'h40, 1, 1, 32'h40, 1, 1, 32'h20, 0, 32'h44, 0, 32'h44, 1, 32'h20);
    look("lk_hit", 32'h40, 1, 32'h20);
    step("tr_t2", 1, 32'h40, 1, 1, 32'h40, 1, 1, 32'h20, 1, 32'h20, 1, 32'h20, 0, 32'h20);
    step("tr_t3", 1, 32'h40, 1, 1, 32'h40, 1, 1, 32'h20, 1, 32'h20, 1, 32'h20, 0, 32'h20);
    step("tr_n1", 1, 32'h40, 1, 1, 32'h40, 1, 0, 32'h20, 1, 32'h20, 1, 32'h20, 1, 32'h44);
    step("tr_n2", 1, 32'h40, 1, 1, 32'h40, 1, 0, 32'h20, 1, 32'h20, 1, 32'h20, 1, 32'h44);
    look("lk_nt", 32'h40, 0, 32'h20);
    step("tr_newtgt", 1, 32'h40, 1, 1, 32'h40, 1, 1, 32'h30, 0, 32'h20, 0, 32'h20, 1, 32'h30);
    look("lk_newtgt", 32'h40, 1, 32'h30);
    step("tr_tgtmis", 1, 32'h44, 1, 1, 32'h40, 1, 1, 32'h34, 1, 32'h30, 0, 32'h48, 1, 32'h34);
    // 0x80 shares index 0 with 0x40 and evicts it.
    step("al_80", 1, 32'h80, 1, 1, 32'h80, 1, 1, 32'h100, 0, 32'h84, 0, 32'h84, 1, 32'h100);
    look("al_40", 32'h40, 0, 32'h44);
    look("al_80hit", 32'h80, 1, 32'h100);
    step("cl_ex", 1, 32'h80, 1, 1, 32'h80, 0, 0, 32'h0, 1, 32'h100, 1, 32'h100, 1, 32'h84);
    look("cl_lk", 32'h80, 0, 32'h84);
    step("fl_ex", 1, 32'h200, 1, 0, 32'h40, 1, 1, 32'h20, 0, 32'h44, 0, 32'h204, 0, 32'h20);
    look("fl_lk", 32'h40, 0, 32'h44);
    step("jal1", 1, 32'h10, 1, 1, 32'h10, 1, 1, 32'h200, 0, 32'h14, 0, 32'h14, 1, 32'h200);
    look("jal_lk", 32'h10, 1, 32'h200);
    step("jal2", 1, 32'h10, 1, 1, 32'h10, 1, 1, 32'h200, 0, 32'h14, 1, 32'h200, 1, 32'h200);
    step("rst_mid", 0, 32'h10, 1, 1, 32'h40, 1, 1, 32'h20, 0, 32'h44, 0, 32'h0, 0, 32'h0);
    look("rst_lk", 32'h10, 0, 32'h14);
    for (int i = 0; i < 20; i++) look($sformatf("sat%0d", i), 32'h0, 0, 32'h4);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(posedge clk);
    check_val("drain", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_btb.md
# branch_predictor_btb

Parametrised branch target buffer with per-entry 2-bit saturating predictors for the 5-stage core. Sits beside the IF-stage program counter: it predicts taken/target in the same cycle as instruction fetch. It accepts resolution from the EX stage, where branches and jumps are still resolved. It flags mispredictions with a redirect PC so the top level can flush IF/ID and ID/EX, and keeps saturating lookup/mispredict statistics.

## Interface
- ENTRIES, 16, number of BTB entries; power of two, at least 2.
- ADDR_W, 32, PC/target width.
- MODE, 1, 0 = static not-taken (PredTaken forced 0, table still trained), 1 = dynamic 2-bit.
- CTR_W, 32, statistics counter width.
- Clk  in  1  single clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-low.
- IF_PC  in  ADDR_W  fetch PC being looked up this cycle.
- IF_Valid  in  1  fetch advancing (PC enable); qualifies lookup statistics.
- PredTaken  out  1  predict taken for IF_PC.
- PredTarget  out  ADDR_W  predicted target (valid when PredTaken).
- EX_Valid  in  1  EX-stage instruction is real (not bubble/flushed).
- EX_PC  in  ADDR_W  PC of EX instruction.
- EX_IsBranch  in  1  EX instruction is beq/bne/j/jal/jr.
- EX_Taken  in  1  resolved direction (1 for all jumps).
- EX_Target  in  ADDR_W  resolved target.
- EX_PredTaken, EX_PredTarget  in  1, ADDR_W  prediction carried down the pipe with the instruction.
- Mispredict  out  1  flush request.
- RedirectPC  out  ADDR_W  correct next PC when Mispredict.
- LookupCount, MispredCount  out  CTR_W  statistics.

## Operation
- Index = PC[IDX_W+1:2], IDX_W = log2(ENTRIES); tag = PC[ADDR_W-1:IDX_W+2]. Entry = {valid, tag, target, ctr[1:0]}.
- Lookup (combinational): hit = valid && tag match. PredTaken = MODE && hit && ctr[1]; PredTarget = entry target. On miss, PredTarget = IF_PC+4.
- Update (at edge, when EX_Valid && EX_IsBranch):
  - On hit: ctr saturating increment if EX_Taken, else saturating decrement (00 and 11 hold). Target is overwritten with EX_Target when taken.
  - On miss and taken: allocate, overwriting the resident entry. valid=1, tag, target=EX_Target, ctr=10.
  - On miss and not taken: no change.
- Alias clean-up: EX_Valid && !EX_IsBranch && EX_PredTaken means the entry at EX_PC's index is cleared (valid=0).
- Mispredict (combinational, EX_Valid required) is asserted when:
  - EX_IsBranch && EX_PredTaken != EX_Taken; or
  - EX_IsBranch && EX_Taken && EX_PredTarget != EX_Target; or
  - !EX_IsBranch && EX_PredTaken.
- RedirectPC = (EX_IsBranch && EX_Taken) ? EX_Target : EX_PC+4.
- Statistics:
  - LookupCount increments when IF_Valid.
  - MispredCount increments when Mispredict.
  - Both saturate at all-ones.
- MODE=0 is identical except PredTaken=0. Mispredict then fires on every taken branch/jump, which matches the existing EX-resolve behaviour.

## Timing
- Prediction has zero latency (same cycle as IF_PC). Update becomes visible to lookups from the cycle after the EX edge.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents; there is no bypass.
- Mispredict and RedirectPC are combinational from EX inputs. The top level registers the flush.
- Reset low at an edge:
  - all valid bits clear and all ctr take 01;
  - LookupCount and MispredCount become 0.
- While Reset is low, PredTaken=0, Mispredict=0 and RedirectPC=0, regardless of other inputs.
- Reset mid-operation discards any pending update in that cycle.
- Flushed instructions arrive with EX_Valid=0: no update and no Mispredict.

## Structure
- Shared package `bp_pkg`:
  - counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - entry struct typedef;
  - index/tag width functions from ENTRIES/ADDR_W.
- Sub-module `bp_sat_ctr2`: 2-bit saturating next-state (taken, ctr → ctr').
- Table is flop-based, not block RAM, because lookup is asynchronous.

## Test plan
- After reset, lookup IF_PC=0x40 -> PredTaken=0, PredTarget=0x44. One EX taken beq at 0x40 to 0x20 -> Mispredict=1, RedirectPC=0x20. Next cycle, lookup 0x40 -> PredTaken=1, PredTarget=0x20.
- Train 0x40 taken three times, then resolve not-taken twice -> ctr sequence 10,11,11,10,01. PredTaken goes 1 then 0 after the second not-taken. RedirectPC=0x44 on the not-taken mispredicts.
- Aliasing with ENTRIES=16:
  - Train 0x40 taken to 0x20, then train 0x80 taken to 0x100 (same index, different tag).
  - Then lookup 0x40 -> miss, PredTaken=0.
- Alias clean-up: EX non-branch with EX_PredTaken=1 -> Mispredict=1, RedirectPC=EX_PC+4, and that entry is invalidated.
- Same-cycle update and lookup at the same index returns old data. Reset low mid-stream clears all predictions and counters, and holds PredTaken/Mispredict at 0.
- Statistics:
  - With CTR_W=4, apply 20 IF_Valid cycles -> LookupCount saturates at 15.
  - With MODE=0, every taken jal raises Mispredict.
